carfield_addr_map_unit: RTL
===========================

CARFIELD_ADDR_MAP_UNIT -- requirements
Module: carfield_addr_map_unit

Interface
REQ-001 SHALL have parameter NumRegions, default 8, number of programmable regions (1..16).
REQ-002 SHALL have parameter AddrWidth, default 64, width of decoded address and region base/size.
REQ-003 SHALL have parameter MissCntWidth, default 16, width of saturating miss counter.
REQ-004 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports cfg_req_i in 1, cfg_we_i in 1, cfg_addr_i in 10, cfg_wdata_i in 32: config register-bus request.
REQ-007 SHALL have ports cfg_rdata_o out 32, cfg_ready_o out 1, cfg_error_o out 1: config response.
REQ-008 SHALL have ports dec_valid_i in 1, dec_ready_o out 1, dec_addr_i in AddrWidth: decode request.
REQ-009 SHALL have ports dec_valid_o out 1, dec_ready_i in 1, dec_hit_o out 1, dec_idx_o out $clog2(NumRegions) (min 1): decode result.
REQ-010 SHALL have port overlap_o  out  1  any two enabled non-empty regions intersect.

Function
REQ-011 SHALL map region i at cfg_addr 0x10*i: +0x0 BASE_LO, +0x4 BASE_HI, +0x8 SIZE_LO, +0xC SIZE_HI; HI words hold bits AddrWidth-1:32, unused bits read 0.
REQ-012 SHALL map CTRL at 0x100: bits NumRegions-1:0 region enables, bit 31 lock; other bits read 0.
REQ-013 SHALL map STATUS at 0x104, read-only: bit 0 overlap, bits 31:16 miss counter (zero-extended/truncated to 16).
REQ-014 SHALL assert cfg_ready_o combinationally with cfg_req_i; every access completes in the same cycle.
REQ-015 SHALL raise cfg_error_o for unmapped addresses, regions >= NumRegions, writes to STATUS, and any write while lock=1; erroring writes have no effect, reads of unmapped addresses return 0.
REQ-016 SHALL make lock sticky: once written 1, cleared only by reset.
REQ-017 SHALL match region i when enable[i]=1, size!=0, addr>=base and (addr-base)<size, computed in AddrWidth bits with no overflow.
REQ-018 SHALL resolve multiple matches to the lowest index.
REQ-019 SHALL implement one output register stage: dec_ready_o = !dec_valid_o || dec_ready_i; on dec_valid_i && dec_ready_o capture hit/idx, latency exactly 1 cycle.
REQ-020 SHALL hold dec_valid_o, dec_hit_o, dec_idx_o stable while dec_valid_o=1 and dec_ready_i=0.
REQ-021 SHALL output dec_hit_o=0, dec_idx_o=0 on a miss.
REQ-022 SHALL use the register values present in the acceptance cycle; a same-cycle config write affects only later requests.
REQ-023 SHALL increment the miss counter on each accepted missing request, saturating at all-ones.
REQ-024 SHALL compute overlap_o combinationally from current registers as a pairwise check over enabled, non-empty regions.
REQ-025 SHALL support full throughput: one request accepted per cycle when dec_ready_i=1.

Reset
REQ-026 SHALL on rst_ni=0 asynchronously clear all bases, sizes, enables, lock, miss counter, dec_valid_o, dec_hit_o, dec_idx_o; overlap_o thus 0.
REQ-027 SHALL drop any in-flight result when reset asserts mid-operation; first post-reset request sees reset register values (all miss).

Verification
REQ-028 SHALL cover: region0 base 0x7800_0000 size 0x20_0000, region1 base 0x7820_0000 size 0x20_0000, both enabled; addr 0x781F_FFFF -> hit idx0 next cycle; 0x7820_0000 -> hit idx1; 0x7840_0000 -> miss, counter 1.
REQ-029 SHALL cover: region2 base 0x2000_1000 size 0x9000 and region3 base 0x2000_4000 size 0x1000 enabled -> overlap_o=1; addr 0x2000_4000 -> idx2; disable region2 -> overlap_o=0, idx3.
REQ-030 SHALL cover: write CTRL bit31=1, then write BASE_LO region0 -> cfg_error_o=1, readback unchanged; reset -> lock 0.
REQ-031 SHALL cover: dec_ready_i=0 three cycles with back-to-back requests -> dec_ready_o=0 after first, output held, no loss or duplication when released.
REQ-032 SHALL cover: size=0 region enabled -> never hits; base=all-ones-0xF, size 0x10 -> addr all-ones hits without wrap; 2^16 misses -> counter saturates at 0xFFFF.

Source files
------------

// File: rtl/carfield_addr_map_unit.sv
// Programmable address-map decoder.
// Holds NumRegions base/size windows behind a 32-bit config register bus,
// decodes one address per cycle through a single output register stage,
// counts decode misses (saturating) and flags overlapping enabled regions.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   cfg_req_i/we_i/addr_i/wdata_i   config request (completes same cycle)
//   cfg_rdata_o/ready_o/error_o     config response (combinational)
//   dec_valid_i/ready_o/addr_i      decode request handshake
//   dec_valid_o/ready_i/hit_o/idx_o decode result handshake (registered)
//   overlap_o              any two enabled, non-empty regions intersect
//
// Config map: region i at 0x10*i (BASE_LO, BASE_HI, SIZE_LO, SIZE_HI),
// CTRL at 0x100 (enables, bit 31 sticky lock), STATUS at 0x104 (read-only).
// Accesses must be word aligned; AddrWidth is supported from 1 to 64.
module carfield_addr_map_unit #(
  parameter int unsigned NumRegions   = 8,
  parameter int unsigned AddrWidth    = 64,
  parameter int unsigned MissCntWidth = 16,
  localparam int unsigned IdxWidth    = (NumRegions > 1) ? $clog2(NumRegions) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cfg_req_i,
  input  logic                 cfg_we_i,
  input  logic [9:0]           cfg_addr_i,
  input  logic [31:0]          cfg_wdata_i,
  output logic [31:0]          cfg_rdata_o,
  output logic                 cfg_ready_o,
  output logic                 cfg_error_o,
  input  logic                 dec_valid_i,
  output logic                 dec_ready_o,
  input  logic [AddrWidth-1:0] dec_addr_i,
  output logic                 dec_valid_o,
  input  logic                 dec_ready_i,
  output logic                 dec_hit_o,
  output logic [IdxWidth-1:0]  dec_idx_o,
  output logic                 overlap_o
);

  localparam logic [9:0] CtrlAddr   = 10'h100;
  localparam logic [9:0] StatusAddr = 10'h104;

  logic [AddrWidth-1:0]    base_q [NumRegions];
  logic [AddrWidth-1:0]    size_q [NumRegions];
  logic [NumRegions-1:0]   en_q;
  logic                    lock_q;
  logic [MissCntWidth-1:0] miss_q;

  // Replace the low or high 32-bit word of an AddrWidth-bit register.
  function automatic logic [AddrWidth-1:0] merge_word(input logic [AddrWidth-1:0] cur,
                                                      input logic hi,
                                                      input logic [31:0] wd);
    logic [63:0] t;
    t = 64'(cur);
    if (hi) t[63:32] = wd;
    else    t[31:0]  = wd;
    return AddrWidth'(t);
  endfunction

  // Select one 32-bit view of a region; bits above AddrWidth read as zero.
  function automatic logic [31:0] read_word(input logic [AddrWidth-1:0] base,
                                            input logic [AddrWidth-1:0] size,
                                            input logic [1:0] word);
    logic [63:0] b;
    logic [63:0] s;
    b = 64'(base);
    s = 64'(size);
    case (word)
      2'd0:    return b[31:0];
      2'd1:    return b[63:32];
      2'd2:    return s[31:0];
      default: return s[63:32];
    endcase
  endfunction

  // ---------------- config bus decode ----------------
  logic [3:0]  reg_sel;
  logic [1:0]  word_sel;
  logic        is_region;
  logic        wr_region;
  logic        wr_ctrl;
  logic [31:0] region_rdata;
  logic [31:0] ctrl_rdata;

  assign reg_sel     = cfg_addr_i[7:4];
  assign word_sel    = cfg_addr_i[3:2];
  assign is_region   = (cfg_addr_i[9:8] == 2'b00) && (cfg_addr_i[1:0] == 2'b00) &&
                       (32'(reg_sel) < NumRegions);
  assign cfg_ready_o = cfg_req_i;

  // Read mux over the selected region.
  always_comb begin
    region_rdata = '0;
    for (int i = 0; i < NumRegions; i++) begin
      if (reg_sel == 4'(i)) region_rdata = read_word(base_q[i], size_q[i], word_sel);
    end
  end

  always_comb begin
    ctrl_rdata     = 32'(en_q);
    ctrl_rdata[31] = lock_q;
  end

  // Response and write strobes; erroring accesses never produce a write.
  always_comb begin
    cfg_rdata_o = '0;
    cfg_error_o = 1'b0;
    wr_region   = 1'b0;
    wr_ctrl     = 1'b0;
    if (cfg_req_i) begin
      if (is_region) begin
        if (!cfg_we_i)   cfg_rdata_o = region_rdata;
        else if (lock_q) cfg_error_o = 1'b1;
        else             wr_region   = 1'b1;
      end else if (cfg_addr_i == CtrlAddr) begin
        if (!cfg_we_i)   cfg_rdata_o = ctrl_rdata;
        else if (lock_q) cfg_error_o = 1'b1;
        else             wr_ctrl     = 1'b1;
      end else if (cfg_addr_i == StatusAddr) begin
        if (!cfg_we_i)   cfg_rdata_o = {16'(miss_q), 15'b0, overlap_o};
        else             cfg_error_o = 1'b1;
      end else begin
        cfg_error_o = 1'b1;
      end
    end
  end

  // ---------------- address match ----------------
  logic                  hit_c;
  logic [IdxWidth-1:0]   idx_c;
  logic                  dec_accept;
  logic [NumRegions-1:0] active;
  logic [AddrWidth:0]    region_end [NumRegions];

  // Region extents carry one extra bit so base+size never wraps.
  always_comb begin
    for (int i = 0; i < NumRegions; i++) begin
      active[i]     = en_q[i] && (size_q[i] != '0);
      region_end[i] = {1'b0, base_q[i]} + {1'b0, size_q[i]};
    end
  end

  // Lowest-index match wins; addr >= base makes the subtraction safe.
  always_comb begin
    hit_c = 1'b0;
    idx_c = '0;
    for (int i = 0; i < NumRegions; i++) begin
      if (!hit_c && active[i] && (dec_addr_i >= base_q[i]) &&
          ((dec_addr_i - base_q[i]) < size_q[i])) begin
        hit_c = 1'b1;
        idx_c = IdxWidth'(i);
      end
    end
  end

  // Pairwise interval intersection over active regions.
  always_comb begin
    overlap_o = 1'b0;
    for (int i = 0; i < NumRegions; i++) begin
      for (int j = i + 1; j < NumRegions; j++) begin
        if (active[i] && active[j] &&
            ({1'b0, base_q[i]} < region_end[j]) &&
            ({1'b0, base_q[j]} < region_end[i])) begin
          overlap_o = 1'b1;
        end
      end
    end
  end

  assign dec_ready_o = !dec_valid_o || dec_ready_i;
  assign dec_accept  = dec_valid_i && dec_ready_o;

  // ---------------- state ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumRegions; i++) begin
        base_q[i] <= '0;
        size_q[i] <= '0;
      end
      en_q        <= '0;
      lock_q      <= 1'b0;
      miss_q      <= '0;
      dec_valid_o <= 1'b0;
      dec_hit_o   <= 1'b0;
      dec_idx_o   <= '0;
    end else begin
      if (wr_region) begin
        for (int i = 0; i < NumRegions; i++) begin
          if (reg_sel == 4'(i)) begin
            case (word_sel)
              2'd0:    base_q[i] <= merge_word(base_q[i], 1'b0, cfg_wdata_i);
              2'd1:    base_q[i] <= merge_word(base_q[i], 1'b1, cfg_wdata_i);
              2'd2:    size_q[i] <= merge_word(size_q[i], 1'b0, cfg_wdata_i);
              default: size_q[i] <= merge_word(size_q[i], 1'b1, cfg_wdata_i);
            endcase
          end
        end
      end
      if (wr_ctrl) begin
        en_q   <= cfg_wdata_i[NumRegions-1:0];
        lock_q <= lock_q | cfg_wdata_i[31];
      end
      // Output stage: load on accept, drop valid once consumed, else hold.
      if (dec_accept) begin
        dec_valid_o <= 1'b1;
        dec_hit_o   <= hit_c;
        dec_idx_o   <= idx_c;
      end else if (dec_ready_i) begin
        dec_valid_o <= 1'b0;
      end
      if (dec_accept && !hit_c && (miss_q != {MissCntWidth{1'b1}})) begin
        miss_q <= miss_q + MissCntWidth'(1);
      end
    end
  end

endmodule
